// File: rtl/robs_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : robs_pkg                                                  |
// | Purpose  : Shared defaults and ALU op encoding for the Robertson's   |
// |            signed-multiplier arithmetic units.                       |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
package robs_pkg;

  // Default datapath / counter geometry
  localparam int DEF_WIDTH     = 8;
  localparam int DEF_CNT_WIDTH = 3;
  localparam int DEF_CNT_INIT  = 7;

  // Adder/subtractor operation select encoding
  localparam logic ADD = 1'b0;
  localparam logic SUB = 1'b1;

endpackage
`default_nettype wire

// File: rtl/robs_arith_units_register.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : register                                                  |
// | Purpose  : WIDTH-bit load/clear register (Y, A and X operand regs).  |
// |            Synchronous clear has priority over load; async reset.    |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module register
  import robs_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  input  logic             load,
  input  logic             clr,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] val_d;
  logic [WIDTH-1:0] val_q;

  // Next value: clear beats load, otherwise hold
  always_comb begin
    val_d = val_q;
    if (clr) begin
      val_d = '0;
    end else if (load) begin
      val_d = d;
    end
  end

  // Storage flop with asynchronous active-low reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      val_q <= '0;
    end else begin
      val_q <= val_d;
    end
  end

  assign q = val_q;

endmodule
`default_nettype wire

// File: rtl/robs_arith_units.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : robs_arith_units                                          |
// | Purpose  : Operand register, registered adder/subtractor and         |
// |            iteration down-counter for the Robertson's multiplier.    |
// |            The three units are independent and share one clock.      |
// | Options  : ROBS_ADDSUB_OVF_EN - registered two's-complement overflow |
// |            flag on as_ovf; when undefined as_ovf is tied low.        |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module robs_arith_units
  import robs_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int CNT_WIDTH = DEF_CNT_WIDTH,
  parameter int CNT_INIT  = DEF_CNT_INIT
) (
  input  logic                 clk,
  input  logic                 reset,
  // operand register
  input  logic [WIDTH-1:0]     reg_d,
  input  logic                 reg_load,
  input  logic                 reg_clr,
  output logic [WIDTH-1:0]     reg_q,
  // adder/subtractor
  input  logic [WIDTH-1:0]     as_a,
  input  logic [WIDTH-1:0]     as_b,
  input  logic                 as_sub,
  output logic [WIDTH-1:0]     as_y,
  output logic                 as_ovf,
  // iteration counter
  input  logic                 cnt_load,
  input  logic                 cnt_dec,
  output logic [CNT_WIDTH-1:0] cnt_q,
  output logic                 cnt_zero
);

  localparam logic [CNT_WIDTH-1:0] CNT_INIT_V = CNT_INIT[CNT_WIDTH-1:0];

  // ------------------------------------------------------------------
  // Operand register
  // ------------------------------------------------------------------
  register #(
    .WIDTH (WIDTH)
  ) u_reg (
    .clk   (clk),
    .reset (reset),
    .d     (reg_d),
    .load  (reg_load),
    .clr   (reg_clr),
    .q     (reg_q)
  );

  // ------------------------------------------------------------------
  // Adder/subtractor and counter
  // ------------------------------------------------------------------
  logic [WIDTH-1:0]     as_y_d;
  logic [WIDTH-1:0]     as_y_q;
  logic [CNT_WIDTH-1:0] cnt_d;
  logic [CNT_WIDTH-1:0] cnt_q_q;

  // ALU result every cycle; carry/borrow out is dropped by the width
  always_comb begin
    as_y_d = as_a + as_b;
    if (as_sub == SUB) begin
      as_y_d = as_a - as_b;
    end
  end

  // Counter next value: load beats decrement; decrement wraps 0 -> all ones
  always_comb begin
    cnt_d = cnt_q_q;
    if (cnt_load) begin
      cnt_d = CNT_INIT_V;
    end else if (cnt_dec) begin
      cnt_d = cnt_q_q - 1'b1;
    end
  end

  // ALU result and counter state flops
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      as_y_q  <= '0;
      cnt_q_q <= '0;
    end else begin
      as_y_q  <= as_y_d;
      cnt_q_q <= cnt_d;
    end
  end

  assign as_y     = as_y_q;
  assign cnt_q    = cnt_q_q;
  assign cnt_zero = (cnt_q_q == '0);

  // ------------------------------------------------------------------
  // Overflow flag
  // ------------------------------------------------------------------
`ifdef ROBS_ADDSUB_OVF_EN
  logic as_ovf_d;
  logic as_ovf_q;

  // Add overflows when like-signed operands give an unlike-signed sum;
  // subtract overflows when operand signs differ and the result sign
  // no longer matches the minuend.
  always_comb begin
    as_ovf_d = (as_a[WIDTH-1] == as_b[WIDTH-1]) &&
               (as_y_d[WIDTH-1] != as_a[WIDTH-1]);
    if (as_sub == SUB) begin
      as_ovf_d = (as_a[WIDTH-1] != as_b[WIDTH-1]) &&
                 (as_y_d[WIDTH-1] != as_a[WIDTH-1]);
    end
  end

  // Overflow flag registered alongside the ALU result
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      as_ovf_q <= 1'b0;
    end else begin
      as_ovf_q <= as_ovf_d;
    end
  end

  assign as_ovf = as_ovf_q;
`else
  assign as_ovf = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_robs_arith_units.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_robs_arith_units                                       |
// | Purpose  : Scoreboard bench for robs_arith_units: directed cases     |
// |            followed by random traffic against a reference model.     |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module tb_robs_arith_units;

  logic       clk;
  logic       reset;
  logic [7:0] reg_d;
  logic       reg_load;
  logic       reg_clr;
  logic [7:0] reg_q;
  logic [7:0] as_a;
  logic [7:0] as_b;
  logic       as_sub;
  logic [7:0] as_y;
  logic       as_ovf;
  logic       cnt_load;
  logic       cnt_dec;
  logic [2:0] cnt_q;
  logic       cnt_zero;

  robs_arith_units dut (
    .clk      (clk),
    .reset    (reset),
    .reg_d    (reg_d),
    .reg_load (reg_load),
    .reg_clr  (reg_clr),
    .reg_q    (reg_q),
    .as_a     (as_a),
    .as_b     (as_b),
    .as_sub   (as_sub),
    .as_y     (as_y),
    .as_ovf   (as_ovf),
    .cnt_load (cnt_load),
    .cnt_dec  (cnt_dec),
    .cnt_q    (cnt_q),
    .cnt_zero (cnt_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [7:0] reg_v;
    logic [7:0] y;
    logic       ovf;
    logic [2:0] cnt;
    logic       zero;
  } exp_t;

  exp_t sb_q[$];
  event ev_chk;
  int   n_cmp = 0;
  int   n_err = 0;

  // Reference model state
  int reg_m;
  int cnt_m;

  task automatic chk(input string nm, input string fld, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s %s: got %h expected %h", nm, fld, got, exp);
    end
  endtask

  // Monitor: after every rising edge (or an explicit mid-cycle request) pop and compare
  initial begin
    exp_t e;
    forever begin
      @(posedge clk or ev_chk);
      #1;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk(e.name, "reg_q",    reg_q,              e.reg_v);
        chk(e.name, "as_y",     as_y,               e.y);
        chk(e.name, "as_ovf",   {7'd0, as_ovf},     {7'd0, e.ovf});
        chk(e.name, "cnt_q",    {5'd0, cnt_q},      {5'd0, e.cnt});
        chk(e.name, "cnt_zero", {7'd0, cnt_zero},   {7'd0, e.zero});
      end
    end
  end

  // Expected outputs one edge after the currently driven inputs
  function automatic exp_t predict(input string nm);
    exp_t e;
    int sa, sb, res;
    e.name = nm;
    if (reg_clr)       reg_m = 0;
    else if (reg_load) reg_m = int'(reg_d);
    e.reg_v = reg_m[7:0];
    sa = int'($signed(as_a));
    sb = int'($signed(as_b));
    res = as_sub ? (sa - sb) : (sa + sb);
    e.y = res[7:0];
`ifdef ROBS_ADDSUB_OVF_EN
    e.ovf = (res > 127) || (res < -128);
`else
    e.ovf = 1'b0;
`endif
    if (cnt_load)     cnt_m = 7;
    else if (cnt_dec) cnt_m = (cnt_m + 7) % 8;
    e.cnt  = cnt_m[2:0];
    e.zero = (cnt_m == 0);
    return e;
  endfunction

  function automatic exp_t zeros(input string nm);
    exp_t e;
    e.name = nm; e.reg_v = 8'd0; e.y = 8'd0; e.ovf = 1'b0; e.cnt = 3'd0; e.zero = 1'b1;
    return e;
  endfunction

  task automatic drive(input logic [7:0] d, input logic ld, input logic clr,
                       input logic [7:0] a, input logic [7:0] b, input logic sub,
                       input logic cl, input logic cd);
    reg_d = d; reg_load = ld; reg_clr = clr;
    as_a = a; as_b = b; as_sub = sub;
    cnt_load = cl; cnt_dec = cd;
  endtask

  task automatic cycle(input string nm, input logic [7:0] d, input logic ld, input logic clr,
                       input logic [7:0] a, input logic [7:0] b, input logic sub,
                       input logic cl, input logic cd);
    @(negedge clk);
    drive(d, ld, clr, a, b, sub, cl, cd);
    sb_q.push_back(predict(nm));
  endtask

  // Asynchronous reset pulse between edges, checked while reset is low
  task automatic reset_pulse(input string nm);
    @(negedge clk);
    drive(8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    #1;
    sb_q.push_back(zeros(nm));
    reset = 1'b0;
    -> ev_chk;
    #2;
    reset = 1'b1;
    reg_m = 0;
    cnt_m = 0;
    sb_q.push_back(predict({nm, "_post"}));
  endtask

  initial begin
    reset = 1'b0;
    drive(8'h00, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    reg_m = 0;
    cnt_m = 0;
    #2;
    sb_q.push_back(zeros("reset_init"));
    -> ev_chk;
    @(negedge clk);
    reset = 1'b1;

    // Register priority and ALU basics
    cycle("load_3c",    8'h3C, 1, 0, 8'h05, 8'h03, 0, 0, 0);
    cycle("clr_wins",   8'h55, 1, 1, 8'h05, 8'h03, 1, 0, 0);
    cycle("reload_3c",  8'h3C, 1, 0, 8'h00, 8'h01, 1, 0, 0);
    cycle("hold",       8'h99, 0, 0, 8'h7F, 8'h01, 0, 0, 0);
    cycle("sub_ovf",    8'h99, 0, 0, 8'h80, 8'h01, 1, 0, 0);
    cycle("add_noovf",  8'h99, 0, 0, 8'h05, 8'h03, 0, 0, 0);

    // Counter: load, seven decrements to zero, wrap, then load+dec
    cycle("cnt_load",   8'h00, 0, 0, 8'h00, 8'h00, 0, 1, 0);
    for (int i = 0; i < 7; i++)
      cycle("cnt_dec",  8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 1);
    cycle("cnt_wrap",   8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 1);
    cycle("cnt_dec2",   8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 1);
    cycle("cnt_ld_dec", 8'h00, 0, 0, 8'h00, 8'h00, 0, 1, 1);

    // Reset mid-operation
    cycle("pre_reset",  8'hA5, 1, 0, 8'h12, 8'h34, 0, 1, 0);
    reset_pulse("reset_mid");

    // Random traffic with occasional reset pulses
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 59) == 0) begin
        reset_pulse("rand_reset");
      end else begin
        cycle("rand", 8'($urandom), 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 7) == 0),
              8'($urandom), 8'($urandom), 1'($urandom),
              1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 1)));
      end
    end

    repeat (3) @(negedge clk);
    n_cmp++;
    if (sb_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
